// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage.
// Contents: funct3 width codes, FSM state enum, exception cause codes and
// the base byte-lane strobe patterns used when building store strobes.
package lsu_pkg;

    // funct3 width/sign codes. Loads and stores share the low three codes.
    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    localparam logic [1:0] ExcLoadMisaligned  = 2'b00;
    localparam logic [1:0] ExcStoreMisaligned = 2'b01;
    localparam logic [1:0] ExcIllegalWidth    = 2'b10;
    localparam logic [1:0] ExcBusTimeout      = 2'b11;

    // Strobe patterns for a lane-0 access; shifted up by the byte offset.
    localparam logic [3:0] StrbByte = 4'b0001;
    localparam logic [3:0] StrbHalf = 4'b0011;
    localparam logic [3:0] StrbWord = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store stage.
// Access side : is_store, funct3, addr_lo (address bits [1:0]), rs2 in;
//               illegal, misaligned, wstrb, wdata out.
// Load side   : ld_funct3, ld_off (latched address bits [1:0]), rdata in;
//               ld_data (shifted and sign/zero-extended) out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        wstrb      = 4'b0000;
        wdata      = rs2;
        case (funct3)
            F3Byte: begin
                wstrb = StrbByte << addr_lo;
                wdata = {4{rs2[7:0]}};
            end
            F3Half: begin
                misaligned = addr_lo[0];
                wstrb      = StrbHalf << {addr_lo[1], 1'b0};
                wdata      = {2{rs2[15:0]}};
            end
            F3Word: begin
                misaligned = (addr_lo != 2'b00);
                wstrb      = StrbWord;
            end
            // Unsigned widths exist only for loads.
            F3ByteU: illegal = is_store;
            F3HalfU: begin
                illegal    = is_store;
                misaligned = addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3Byte:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3Half:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3ByteU: ld_data = {24'd0, shifted[7:0]};
            F3HalfU: ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access stage behind the RV32IM ALU.
// EX side : ex_valid/ex_ready handshake, ex_is_load, ex_is_store, ex_res
//           (address or result), ex_rs2, ex_funct3, ex_rd.
// Bus side: mem_req/mem_gnt request channel with mem_we, mem_addr,
//           mem_wstrb, mem_wdata held until grant; mem_rvalid/mem_rdata.
// WB side : wb_valid pulse with wb_we, wb_rd, wb_data; exc_valid pulse with
//           exc_cause and exc_addr. Writeback never stalls.
// TIMEOUT_CYCLES bounds cycles spent in REQ+WAIT; 0 disables the watchdog.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [31:0] ex_res,
    input  logic [31:0] ex_rs2,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    state_e      state;
    logic [31:0] cnt;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;

    logic        acc_illegal;
    logic        acc_misaligned;
    logic [3:0]  acc_wstrb;
    logic [31:0] acc_wdata;
    logic [31:0] ld_data;
    logic        timeout_hit;

    assign ex_ready = (state == StIdle);
    assign mem_req  = (state == StReq);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 32'd1);

    // Anything not flagged as a load is checked with store rules.
    lsu_align u_align (
        .is_store   (!ex_is_load),
        .funct3     (ex_funct3),
        .addr_lo    (ex_res[1:0]),
        .rs2        (ex_rs2),
        .illegal    (acc_illegal),
        .misaligned (acc_misaligned),
        .wstrb      (acc_wstrb),
        .wdata      (acc_wdata),
        .ld_funct3  (f3_q),
        .ld_off     (addr_q[1:0]),
        .rdata      (mem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            addr_q    <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_cause <= '0;
            exc_addr  <= '0;
        end else begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            exc_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (ex_valid) begin
                        cnt    <= '0;
                        addr_q <= ex_res;
                        f3_q   <= ex_funct3;
                        rd_q   <= ex_rd;
                        if (!ex_is_load && !ex_is_store) begin
                            wb_valid <= 1'b1;
                            wb_we    <= (ex_rd != 5'd0);
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_res;
                        end else if (acc_illegal) begin
                            exc_valid <= 1'b1;
                            exc_cause <= ExcIllegalWidth;
                            exc_addr  <= ex_res;
                        end else if (acc_misaligned) begin
                            exc_valid <= 1'b1;
                            exc_cause <= ex_is_load ? ExcLoadMisaligned : ExcStoreMisaligned;
                            exc_addr  <= ex_res;
                        end else begin
                            state     <= StReq;
                            mem_we    <= !ex_is_load;
                            mem_addr  <= {ex_res[31:2], 2'b00};
                            mem_wstrb <= ex_is_load ? 4'b0000 : acc_wstrb;
                            mem_wdata <= ex_is_load ? 32'd0 : acc_wdata;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt && mem_we) begin
                        state    <= StIdle;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= '0;
                    end else if (timeout_hit) begin
                        // A load granted on its last allowed cycle still times out.
                        state     <= StIdle;
                        exc_valid <= 1'b1;
                        exc_cause <= ExcBusTimeout;
                        exc_addr  <= addr_q;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (mem_gnt) begin
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        state    <= StIdle;
                        wb_valid <= 1'b1;
                        wb_we    <= (rd_q != 5'd0);
                        wb_rd    <= rd_q;
                        wb_data  <= ld_data;
                    end else if (timeout_hit) begin
                        state     <= StIdle;
                        exc_valid <= 1'b1;
                        exc_cause <= ExcBusTimeout;
                        exc_addr  <= addr_q;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_lsu_stage;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [31:0] ex_res, ex_rs2;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    lsu_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_is_load  (ex_is_load),
        .ex_is_store (ex_is_store),
        .ex_res      (ex_res),
        .ex_rs2      (ex_rs2),
        .ex_funct3   (ex_funct3),
        .ex_rd       (ex_rd),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_addr    (exc_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input bit st, input logic [2:0] f3);
        if (st) return (f3 <= 3'd2);
        return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    function automatic logic [3:0] strobe(input logic [1:0] off, input logic [2:0] f3);
        logic [3:0] s;
        s = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (b >= int'(off) && b < int'(off) + size_of(f3)) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] rs2, input logic [2:0] f3);
        logic [31:0] d;
        for (int b = 0; b < 4; b++) d[8*b +: 8] = rs2[8*(b % size_of(f3)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
        int          bits;
        logic [63:0] mask;
        logic [63:0] v;
        bits = 8 * size_of(f3);
        mask = (64'd1 << bits) - 64'd1;
        v    = {32'd0, rdata} >> (8 * int'(off));
        v    = v & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    bit          model_on = 1'b0;
    bit          busy = 1'b0, granted = 1'b0, t_store = 1'b0;
    int          elapsed = 0;
    logic [31:0] t_addr, t_rs2;
    logic [2:0]  t_f3;
    logic [4:0]  t_rd;
    bit          m_wb_valid = 1'b0, m_wb_we = 1'b0, m_chk_data = 1'b0, m_exc_valid = 1'b0;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data, m_exc_addr;
    logic [1:0]  m_exc_cause;

    task automatic m_exc(input logic [1:0] cause, input logic [31:0] addr);
        m_exc_valid = 1'b1;
        m_exc_cause = cause;
        m_exc_addr  = addr;
    endtask

    task automatic m_wb(input bit we, input logic [4:0] rd, input bit chk, input logic [31:0] d);
        m_wb_valid = 1'b1;
        m_wb_we    = we;
        m_wb_rd    = rd;
        m_chk_data = chk;
        m_wb_data  = d;
    endtask

    always @(posedge clk) begin
        model_on    = 1'b1;
        m_wb_valid  = 1'b0;
        m_exc_valid = 1'b0;
        if (!rst_n) begin
            busy    = 1'b0;
            granted = 1'b0;
        end else if (!busy) begin
            if (ex_valid) begin
                if (!ex_is_load && !ex_is_store) begin
                    m_wb(ex_rd != 5'd0, ex_rd, 1'b1, ex_res);
                end else if (!legal(!ex_is_load, ex_funct3)) begin
                    m_exc(2'b10, ex_res);
                end else if (int'(ex_res[1:0]) % size_of(ex_funct3) != 0) begin
                    m_exc(ex_is_load ? 2'b00 : 2'b01, ex_res);
                end else begin
                    busy    = 1'b1;
                    granted = 1'b0;
                    elapsed = 0;
                    t_store = !ex_is_load;
                    t_addr  = ex_res;
                    t_rs2   = ex_rs2;
                    t_f3    = ex_funct3;
                    t_rd    = ex_rd;
                end
            end
        end else begin
            elapsed++;
            if (!granted && t_store && mem_gnt) begin
                busy = 1'b0;
                m_wb(1'b0, t_rd, 1'b0, 32'd0);
            end else if (granted && mem_rvalid) begin
                busy = 1'b0;
                m_wb(t_rd != 5'd0, t_rd, 1'b1, load_val(mem_rdata, t_addr[1:0], t_f3));
            end else if (TO > 0 && elapsed == int'(TO)) begin
                busy = 1'b0;
                m_exc(2'b11, t_addr);
            end else if (!granted && mem_gnt) begin
                granted = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            cmp("ex_ready", 32'(ex_ready), 32'(!busy));
            cmp("mem_req", 32'(mem_req), 32'(busy && !granted));
            cmp("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
            cmp("exc_valid", 32'(exc_valid), 32'(m_exc_valid));
            if (m_wb_valid) begin
                cmp("wb_we", 32'(wb_we), 32'(m_wb_we));
                cmp("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
                if (m_chk_data) cmp("wb_data", wb_data, m_wb_data);
            end
            if (m_exc_valid) begin
                cmp("exc_cause", 32'(exc_cause), 32'(m_exc_cause));
                cmp("exc_addr", exc_addr, m_exc_addr);
            end
            if (busy && !granted) begin
                cmp("mem_addr", mem_addr, {t_addr[31:2], 2'b00});
                cmp("mem_we", 32'(mem_we), 32'(t_store));
                if (t_store) begin
                    cmp("mem_wstrb", 32'(mem_wstrb), 32'(strobe(t_addr[1:0], t_f3)));
                    cmp("mem_wdata", mem_wdata, lanes(t_rs2, t_f3));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_bus = 1'b0;

    always @(posedge clk) begin
        #2;
        if (rand_bus) begin
            mem_gnt    = ($urandom_range(0, 3) == 0);
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input bit ld, input bit st, input logic [31:0] res,
                          input logic [31:0] rs2, input logic [2:0] f3, input logic [4:0] rd);
        ex_valid    = v;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_res      = res;
        ex_rs2      = rs2;
        ex_funct3   = f3;
        ex_rd       = rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        int  kind;
        logic [31:0] r;
        rst_n      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        cmp("rst_ex_ready", 32'(ex_ready), 32'd1);
        cmp("rst_mem_req", 32'(mem_req), 32'd0);
        cmp("rst_wb_valid", 32'(wb_valid), 32'd0);
        cmp("rst_exc_valid", 32'(exc_valid), 32'd0);
        cmp("rst_mem_addr", mem_addr, 32'd0);
        cmp("rst_wb_data", wb_data, 32'd0);
        rst_n = 1'b1;

        // Back-to-back pass-through.
        set_ex(1, 0, 0, 32'h1234_5678, 0, 3'b000, 5'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("pt_wb_valid", 32'(wb_valid), 32'd1);
            cmp("pt_wb_data", wb_data, 32'h1234_5678);
            cmp("pt_wb_we", 32'(wb_we), 32'd1);
            cmp("pt_ready", 32'(ex_ready), 32'd1);
        end
        set_ex(0, 0, 0, 0, 0, 0, 0);
        step();
        cmp("pt_idle", 32'(wb_valid), 32'd0);

        // LB then LBU at 0x1003, grant on the third REQ cycle.
        for (int u = 0; u < 2; u++) begin
            set_ex(1, 1, 0, 32'h1003, 0, (u == 1) ? 3'b100 : 3'b000, 5'd7);
            step();
            set_ex(0, 0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                if (k > 0) step();
                cmp("lb_req_held", 32'(mem_req), 32'd1);
                cmp("lb_addr_held", mem_addr, 32'h1000);
            end
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h1122_3344;
            step();
            mem_gnt    = 1'b0;
            mem_rdata  = 32'h80FF_FF00;
            cmp("lb_wait_req", 32'(mem_req), 32'd0);
            cmp("lb_gnt_rvalid_ignored", 32'(wb_valid), 32'd0);
            step();
            mem_rvalid = 1'b0;
            cmp("lb_wb_valid", 32'(wb_valid), 32'd1);
            cmp("lb_wb_data", wb_data, (u == 1) ? 32'h0000_0080 : 32'hFFFF_FF80);
            cmp("lb_wb_rd", 32'(wb_rd), 32'd7);
        end

        // SH at 0x2002.
        set_ex(1, 0, 1, 32'h2002, 32'hAAAA_BEEF, 3'b001, 5'd9);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        cmp("sh_req", 32'(mem_req), 32'd1);
        cmp("sh_we", 32'(mem_we), 32'd1);
        cmp("sh_addr", mem_addr, 32'h2000);
        cmp("sh_wstrb", 32'(mem_wstrb), 32'b1100);
        cmp("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        cmp("sh_wb_valid", 32'(wb_valid), 32'd1);
        cmp("sh_wb_we", 32'(wb_we), 32'd0);

        // Faults: misaligned LW, illegal load width, misaligned SW.
        set_ex(1, 1, 0, 32'h3002, 0, 3'b010, 5'd3);
        step();
        cmp("lw_mis_exc", 32'(exc_valid), 32'd1);
        cmp("lw_mis_cause", 32'(exc_cause), 32'd0);
        cmp("lw_mis_addr", exc_addr, 32'h3002);
        cmp("lw_mis_req", 32'(mem_req), 32'd0);
        cmp("lw_mis_wb", 32'(wb_valid), 32'd0);
        set_ex(1, 1, 0, 32'h3000, 0, 3'b011, 5'd3);
        step();
        cmp("ld_ill_exc", 32'(exc_valid), 32'd1);
        cmp("ld_ill_cause", 32'(exc_cause), 32'd2);
        cmp("ld_ill_req", 32'(mem_req), 32'd0);
        set_ex(1, 0, 1, 32'h3001, 0, 3'b010, 5'd3);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        cmp("sw_mis_cause", 32'(exc_cause), 32'd1);

        // Bus timeout: no grant ever.
        set_ex(1, 1, 0, 32'h4000, 0, 3'b010, 5'd4);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        n    = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (mem_req) n++;
            if (exc_valid) seen = 1'b1;
            else step();
        end
        cmp("to_seen", 32'(seen), 32'd1);
        cmp("to_req_cycles", n, 32'd8);
        cmp("to_cause", 32'(exc_cause), 32'd3);
        cmp("to_addr", exc_addr, 32'h4000);
        cmp("to_ready", 32'(ex_ready), 32'd1);

        // Reset while waiting for read data; stale rvalid afterwards.
        set_ex(1, 1, 0, 32'h5000, 0, 3'b010, 5'd6);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        cmp("rw_in_wait", 32'(ex_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cmp("rw_req", 32'(mem_req), 32'd0);
        cmp("rw_ready", 32'(ex_ready), 32'd1);
        cmp("rw_no_wb", 32'(wb_valid), 32'd0);
        cmp("rw_no_exc", 32'(exc_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        cmp("rw_stale_rvalid", 32'(wb_valid), 32'd0);

        // Randomized traffic.
        rand_bus = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            kind = $urandom_range(0, 2);
            r    = $urandom;
            if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
            set_ex($urandom_range(0, 9) < 7, kind == 1, kind == 2, r, $urandom,
                   3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rand_bus   = 1'b0;
        rst_n      = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0);
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
